// File: rtl/bsr_pipe_if.sv
// bsr_pipe_if: operand/result stream bundle between the exponent stage, the shifter and the adder.
interface bsr_pipe_if #(
   parameter int SWIDTH = 5,
   parameter int SAW    = 6,
   parameter int TW     = 4
);
   localparam int DW = 2 ** SWIDTH;
   logic              in_valid;
   logic              in_ready;
   logic [DW-1:0]     in_data;
   logic [SAW-1:0]    in_amt;
   logic [1:0]        in_op;
   logic [TW-1:0]     in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic              out_sticky;
   logic [TW-1:0]     out_tag;
   modport master (
      output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_sticky, out_tag
   );
   modport slave (
      input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_sticky, out_tag
   );
endinterface

// File: rtl/bsr_pipe.sv
// bsr_pipe: pipelined barrel shifter (SRL/SRA/SLL/ROR) with saturation and sticky for mantissa alignment.
module bsr_pipe #(
   parameter int SWIDTH = 5,
   parameter int SAW    = 6,
   parameter int LPS    = 2,
   parameter int TW     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   bsr_pipe_if.slave  bus_io
);
   localparam int DW   = 2 ** SWIDTH;
   localparam int NREG = (SWIDTH + LPS - 1) / LPS;

   typedef enum logic [1:0] {SRL = 2'b00, SRA = 2'b01, SLL = 2'b10, ROR = 2'b11} op_e;

   typedef struct packed {
      logic [DW-1:0]     data;
      logic              sticky;
      logic [SWIDTH-1:0] amt;
      op_e               op;
      logic              fill;
      logic [TW-1:0]     tag;
   } beat_t;

   function automatic logic [DW-1:0] rev(input logic [DW-1:0] d);
      logic [DW-1:0] r;
      for (int n = 0; n < DW; n++) r[n] = d[DW-1-n];
      return r;
   endfunction

   logic [NREG:0] rdy;
   logic          sat;
   logic          fill;
   beat_t         cond_b;

   // Saturated beats enter with their final data and a zero amount, so the levels pass them through.
   always_comb begin
      fill          = (bus_io.in_op == SRA) && bus_io.in_data[DW-1];
      sat           = (bus_io.in_op != ROR) && ((bus_io.in_amt >> SWIDTH) != '0);
      cond_b.data   = sat ? {DW{fill}} : (bus_io.in_op == SLL ? rev(bus_io.in_data) : bus_io.in_data);
      cond_b.sticky = sat && (|bus_io.in_data);
      cond_b.amt    = sat ? '0 : bus_io.in_amt[SWIDTH-1:0];
      cond_b.op     = op_e'(bus_io.in_op);
      cond_b.fill   = fill;
      cond_b.tag    = bus_io.in_tag;
   end

   for (genvar i = 0; i < SWIDTH; i++) begin : g_lvl
      localparam int S = 2 ** i;
      beat_t         in_b;
      beat_t         out_b;
      logic [DW-1:0] lo;
      if (i == 0) begin : g_src
         assign in_b = cond_b;
      end else if (i % LPS == 0) begin : g_src
         assign in_b = g_stg[i/LPS-1].stg_q;
      end else begin : g_src
         assign in_b = g_lvl[i-1].out_b;
      end
      // ROR recycles the dropped low bits as the incoming high bits; other modes shift in filler.
      always_comb begin
         lo    = in_b.data & ({DW{1'b1}} >> (DW - S));
         out_b = in_b;
         if (in_b.amt[i]) begin
            out_b.data   = (in_b.data >> S) | ((in_b.op == ROR ? lo : {DW{in_b.fill}}) << (DW - S));
            out_b.sticky = in_b.sticky | ((in_b.op != ROR) && (|lo));
         end
      end
   end

   for (genvar k = 0; k < NREG; k++) begin : g_stg
      localparam int LAST = (((k + 1) * LPS < SWIDTH) ? (k + 1) * LPS : SWIDTH) - 1;
      beat_t stg_q;
      beat_t stg_d;
      logic  v_q;
      logic  v_in;
      if (k == 0) begin : g_vin
         assign v_in = bus_io.in_valid;
      end else begin : g_vin
         assign v_in = g_stg[k-1].v_q;
      end
      assign rdy[k] = !v_q || rdy[k+1];
      always_comb begin
         stg_d = g_lvl[LAST].out_b;
         if (k == NREG - 1 && stg_d.op == SLL) stg_d.data = rev(stg_d.data);
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q   <= 1'b0;
            stg_q <= '0;
         end else if (rdy[k]) begin
            v_q <= v_in;
            if (v_in) stg_q <= stg_d;
         end
      end
   end

   assign rdy[NREG]         = bus_io.out_ready;
   assign bus_io.in_ready   = rdy[0];
   assign bus_io.out_valid  = g_stg[NREG-1].v_q;
   assign bus_io.out_data   = g_stg[NREG-1].stg_q.data;
   assign bus_io.out_sticky = g_stg[NREG-1].stg_q.sticky;
   assign bus_io.out_tag    = g_stg[NREG-1].stg_q.tag;
endmodule

// File: tb/tb_bsr_pipe.sv
// tb_bsr_pipe: directed scoreboard bench for bsr_pipe covering modes, saturation, backpressure, bubbles and reset.
module tb_bsr_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bsr_pipe_if #(.SWIDTH(5), .SAW(6), .TW(4)) bus ();
   bsr_pipe #(.SWIDTH(5), .SAW(6), .LPS(2), .TW(4)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));

   typedef struct {
      logic [31:0] data;
      logic        sticky;
      logic [3:0]  tag;
      int          t_in;
      bit          lat;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] d;
      logic [5:0]  a;
      logic [31:0] ed;
      logic        es;
   } vec_t;

   exp_t sb[$];
   vec_t vt[16];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   lat_mode = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Independent reference using double-width arithmetic shifts.
   function automatic logic [32:0] model(input logic [31:0] d, input logic [5:0] a, input logic [1:0] op);
      logic [63:0] w;
      logic        s;
      s = (op != 2'd3) && (a >= 6'd32);
      case (op)
         2'd0: begin
            w = {d, 32'h0} >> a;
            return s ? {|d, 32'h0} : {|w[31:0], w[63:32]};
         end
         2'd1: begin
            w = $signed({d, 32'h0}) >>> a;
            return s ? {|d, {32{d[31]}}} : {|w[31:0], w[63:32]};
         end
         2'd2: begin
            w = {32'h0, d} << a;
            return s ? {|d, 32'h0} : {|w[63:32], w[31:0]};
         end
         default: begin
            w = {d, d} >> a[4:0];
            return {1'b0, w[31:0]};
         end
      endcase
   endfunction

   task automatic drive(input logic v, input logic [31:0] d, input logic [5:0] a, input logic [1:0] op,
                        input logic [3:0] tag, input logic orr, input logic [32:0] exp, output bit fired);
      exp_t e;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_amt    = a;
      bus.in_op     = op;
      bus.in_tag    = tag;
      bus.out_ready = orr;
      #1;
      fired = v && bus.in_ready;
      if (fired) begin
         e.data = exp[31:0];
         e.sticky = exp[32];
         e.tag = tag;
         e.t_in = cyc;
         e.lat = lat_mode;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input logic orr);
      bit f;
      drive(1'b0, 32'h0, 6'd0, 2'd0, 4'd0, orr, 33'h0, f);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         idle(1'b1);
         #2;
         n++;
      end
      chk("drain_left", sb.size(), 0);
   endtask

   logic [31:0] held_d;
   logic        held_s;
   logic [3:0]  held_t;
   bit          stalled = 1'b0;

   always @(negedge clk) begin : mon
      exp_t e;
      #2;
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data", bus.out_data, held_d);
            chk("hold_sticky", bus.out_sticky, held_s);
            chk("hold_tag", bus.out_tag, held_t);
         end
         stalled = bus.out_valid && !bus.out_ready;
         held_d = bus.out_data;
         held_s = bus.out_sticky;
         held_t = bus.out_tag;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out: got tag %0d data 0x%h, expected no output", bus.out_tag, bus.out_data);
            end else begin
               e = sb.pop_front();
               chk("out_data", bus.out_data, e.data);
               chk("out_sticky", bus.out_sticky, e.sticky);
               chk("out_tag", bus.out_tag, e.tag);
               if (e.lat) chk("latency", cyc - e.t_in, 3);
            end
         end
      end
   end

   initial begin
      bit fired;
      int k;
      int low;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amt = '0; bus.in_op = '0; bus.in_tag = '0;
      bus.out_ready = 1'b1;
      vt[0]  = '{2'd0, 32'hDEADBEEF, 6'd31, 32'h00000001, 1'b1};
      vt[1]  = '{2'd1, 32'h80000010, 6'd4,  32'hF8000001, 1'b0};
      vt[2]  = '{2'd2, 32'hDEADBEEF, 6'd4,  32'hEADBEEF0, 1'b1};
      vt[3]  = '{2'd3, 32'hDEADBEEF, 6'd8,  32'hEFDEADBE, 1'b0};
      vt[4]  = '{2'd3, 32'hDEADBEEF, 6'd40, 32'hEFDEADBE, 1'b0};
      vt[5]  = '{2'd0, 32'h00000001, 6'd40, 32'h00000000, 1'b1};
      vt[6]  = '{2'd1, 32'h80000000, 6'd63, 32'hFFFFFFFF, 1'b1};
      vt[7]  = '{2'd2, 32'h00000000, 6'd32, 32'h00000000, 1'b0};
      vt[8]  = '{2'd1, 32'h92345678, 6'd0,  32'h92345678, 1'b0};
      vt[9]  = '{2'd2, 32'h87654321, 6'd0,  32'h87654321, 1'b0};
      vt[10] = '{2'd3, 32'h87654321, 6'd0,  32'h87654321, 1'b0};
      vt[11] = '{2'd0, 32'h000000F0, 6'd4,  32'h0000000F, 1'b0};
      vt[12] = '{2'd1, 32'h7FFFFFFF, 6'd40, 32'h00000000, 1'b1};
      vt[13] = '{2'd3, 32'h12345678, 6'd4,  32'h81234567, 1'b0};
      vt[14] = '{2'd2, 32'h00000003, 6'd31, 32'h80000000, 1'b1};
      vt[15] = '{2'd3, 32'h00000001, 6'd63, 32'h00000002, 1'b0};

      repeat (2) @(negedge clk);
      #3;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_sticky", bus.out_sticky, 0);
      chk("rst_out_tag", bus.out_tag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #3;
      chk("ready_after_rst", bus.in_ready, 1);

      for (int i = 0; i < 16; i++) begin
         drive(1'b1, vt[i].d, vt[i].a, vt[i].op, 4'(i), 1'b1, {vt[i].es, vt[i].ed}, fired);
         chk("dir_accept", fired, 1);
      end
      drain();

      lat_mode = 1'b0;
      k = 0;
      low = 0;
      for (int n = 0; n < 100 && k < 8; n++) begin
         drive(1'b1, 32'h8421F00F ^ (32'h11111111 * k), 6'(k), 2'(k), 4'(k), !(n >= 4 && n <= 9),
               model(32'h8421F00F ^ (32'h11111111 * k), 6'(k), 2'(k)), fired);
         if (!bus.in_ready) low++;
         if (fired) k++;
      end
      chk("bp_beats_sent", k, 8);
      chk("bp_ready_low_cycles", low, 6);
      drain();

      lat_mode = 1'b1;
      for (int n = 0; n < 10; n++) begin
         drive(n % 2 == 0, 32'hC0FFEE01 + n, 6'(3 * n + 1), 2'(n / 2), 4'(8 + n / 2), 1'b1,
               model(32'hC0FFEE01 + n, 6'(3 * n + 1), 2'(n / 2)), fired);
         chk("bubble_ready", bus.in_ready, 1);
      end
      drain();

      lat_mode = 1'b0;
      for (int n = 0; n < 3; n++)
         drive(1'b1, 32'hA5A5A5A5, 6'(n + 1), 2'd0, 4'(12 + n), 1'b0, model(32'hA5A5A5A5, 6'(n + 1), 2'd0), fired);
      repeat (3) idle(1'b0);
      chk("pre_rst_valid", bus.out_valid, 1);
      chk("pre_rst_full", bus.in_ready, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", bus.out_valid, 0);
      chk("async_rst_data", bus.out_data, 0);
      chk("async_rst_tag", bus.out_tag, 0);
      sb.delete();
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #3;
      chk("ready_after_rst2", bus.in_ready, 1);
      for (int n = 0; n < 6; n++) begin
         idle(1'b1);
         #3;
         chk("no_stale_beat", bus.out_valid, 0);
      end
      lat_mode = 1'b1;
      drive(1'b1, vt[2].d, vt[2].a, vt[2].op, 4'd5, 1'b1, {vt[2].es, vt[2].ed}, fired);
      chk("post_rst_accept", fired, 1);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/bsr_pipe.md
Name: bsr_pipe

Overview:
- Pipelined, parametrised barrel shifter for the FPU datapath; successor to the combinational right-shifter.
- Adds four shift modes, shift amounts wider than log2(width) with saturation, and a sticky output (OR of discarded bits) for mantissa alignment.
- Registered pipeline with valid/ready handshake and per-stage backpressure.
- Sits between exponent compare/swap and the mantissa adder.

Parameters:
- SWIDTH, 5: log2 of data width; DW = 2**SWIDTH (default 32).
- SAW, 6: shift-amount width; must be >= SWIDTH.
- LPS, 2: mux levels per register stage; NREG = ceil(SWIDTH/LPS) (default 3).
- TW, 4: width of the sideband tag carried alongside data.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block can accept a beat this cycle.
- in_data, in, DW: operand.
- in_amt, in, SAW: shift amount, unsigned.
- in_op, in, 2: mode. 00 SRL, 01 SRA, 10 SLL, 11 ROR.
- in_tag, in, TW: sideband, passed through unchanged.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- out_data, out, DW: shifted result.
- out_sticky, out, 1: OR of all bits discarded by the shift.
- out_tag, out, TW: tag of the beat on out_data.

Behaviour:
- Reset: asynchronous, active-low; clk single domain.
  - While rst_n=0, every stage valid bit = 0, out_valid = 0, out_data = 0, out_sticky = 0, out_tag = 0.
  - Pipeline contents are discarded; nothing is replayed after reset.
  - in_ready = 1 from the first cycle after reset deassertion.
- Handshake:
  - A transfer occurs on a rising edge when valid && ready on that interface.
  - Stage k advances when it is empty or stage k+1 accepts: ready_k = !valid_k || ready_{k+1}, where ready_NREG = out_ready and in_ready = ready_0.
  - Bubbles collapse.
  - Payload and tag of a held stage stay stable while stalled.
  - out_data, out_sticky and out_tag stay stable while out_valid && !out_ready.
- Latency:
  - NREG cycles from input transfer to out_valid when out_ready is held at 1.
  - Throughput is 1 beat/cycle.
- Input conditioning (before stage 0 registers):
  - Saturation: sat = (in_amt >= DW) for SRL, SRA and SLL.
  - ROR uses in_amt mod DW; ROR never saturates.
  - filler = in_data[DW-1] for SRA, otherwise 0.
- Mux levels:
  - Level i (0..SWIDTH-1) shifts by 2**i when amt[i]=1.
  - Levels are grouped LPS per register stage, low levels first; amt, op, filler, sat and tag are piped with the data.
  - SLL and ROR are implemented on the same right-shift levels: SLL by bit-reversal at input and output; ROR by wrapping the shifted-out bits in place of filler.
- Sticky:
  - Accumulates per level as an OR of the bits dropped at that level.
  - SRL/SRA: dropped bits are the LSBs shifted out.
  - SLL: dropped bits are the MSBs shifted out.
  - ROR: sticky = 0.
  - Sticky is the OR of original operand bits, not filler bits.
- Saturated result:
  - out_data = {DW{filler}} for SRL/SRA and 0 for SLL.
  - out_sticky = |in_data.
- Amount 0: out_data = in_data, sticky = 0, for all modes.
- Simultaneous events: input and output transfers in the same cycle with a full pipeline are legal; occupancy is unchanged and no beat is lost or duplicated.
- Ordering: results leave in input order; tags identify each beat.
- No combinational path from in_* to out_*.
  - in_ready depends combinationally on out_ready and the stage valids only.

Test Plan:
- SRL, in_data=0xDEADBEEF, amt=31, out_ready=1 -> after 3 cycles out_data=0x00000001, out_sticky=1.
- SRA 0x80000010 amt=4 -> 0xF8000001, sticky=0. SLL 0xDEADBEEF amt=4 -> 0xEADBEEF0, sticky=1. ROR 0xDEADBEEF amt=8 -> 0xEFDEADBE, sticky=0. ROR amt=40 -> same as amt=8.
- Saturation:
  - SRL 0x00000001 amt=40 -> 0x00000000, sticky=1.
  - SRA 0x80000000 amt=63 -> 0xFFFFFFFF, sticky=1.
  - SLL 0 amt=32 -> 0, sticky=0.
- Backpressure:
  - Stream 8 beats, tags 0..7, amt=k, in_valid=1.
  - out_ready low for cycles 4-9 -> in_ready drops once 3 beats are held.
  - Held out_data stays stable; all 8 results arrive in tag order, none dropped or duplicated.
- Bubbles: in_valid alternating 1/0 with out_ready=1 -> outputs alternate with 3-cycle latency; in_ready stays 1.
- Reset: assert rst_n=0 mid-stream with 3 beats in flight -> out_valid=0 and out_data=0 immediately (asynchronous), no stale beat emitted after release, in_ready=1 on the first clock after release.
